// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline control for the 5-stage NPC pipeline.
//
// Sequences the IF/ID and ID/EX stage registers: flush on a taken jump or
// an interrupt, load-use stall, redirect-PC generation for the IFU, and an
// ebreak drain-and-halt sequence.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_jump, ex_jump_target   EX taken jump/branch and its target
//   intr_req, intr_vec        interrupt taken this cycle and trap vector
//   id_ebreak                 ebreak decoded in ID
//   id/ex/mem/wb_valid        stage valid bits
//   id_rs1/rs2, id_use_rs1/2  ID source indices and their read enables
//   ex_rd, ex_is_load         EX destination and load flag
//   flush_if_id, flush_id_ex  clear stage register valid (combinational)
//   stall_id                  hold ID, bubble into EX (combinational)
//   fetch_stop                IFU must not issue new fetches
//   redirect_valid/_pc        one-cycle registered redirect to the IFU
//   halted                    ebreak retired, sticky until reset
//   ctrl_state                FSM state for debug
//   flush_cnt, stall_cnt      perf counters
//
// Build option: define PIPE_CTRL_PERF_EN to enable the saturating perf
// counters; otherwise flush_cnt/stall_cnt are tied to zero.

module pipe_ctrl #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_jump,
    input  logic [XLEN-1:0]       ex_jump_target,
    input  logic                  intr_req,
    input  logic [XLEN-1:0]       intr_vec,
    input  logic                  id_ebreak,
    input  logic                  id_valid,
    input  logic                  ex_valid,
    input  logic                  mem_valid,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  stall_id,
    output logic                  fetch_stop,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  halted,
    output logic [1:0]            ctrl_state,
    output logic [31:0]           flush_cnt,
    output logic [31:0]           stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            halted_q, halted_d;

    logic jmp, ebk, evt, evt_ok, src_hit;

    assign jmp = ex_jump & ex_valid;
    assign ebk = id_ebreak & id_valid;
    assign evt = intr_req | jmp;

    // Jumps/interrupts act in RUN and DRAIN only; REDIRECT has already
    // flushed the pipeline and HALT ignores everything.
    assign evt_ok = (state_q == RUN) || (state_q == DRAIN);

    assign src_hit = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd));

    assign flush_id_ex = evt_ok & evt;
    // DRAIN discards everything younger than the ebreak.
    assign flush_if_id = flush_id_ex | (state_q == DRAIN);
    assign stall_id    = (state_q == RUN) & id_valid & ex_valid & ex_is_load &
                         (ex_rd != '0) & src_hit & ~flush_id_ex;
    assign fetch_stop  = (state_q == DRAIN) || (state_q == HALT);

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        halted_d         = halted_q;
        case (state_q)
            RUN: begin
                if (evt) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = intr_req ? intr_vec : ex_jump_target;
                end else if (ebk) begin
                    state_d = DRAIN;
                end
            end
            REDIRECT: state_d = RUN;
            DRAIN: begin
                // An older jump/interrupt kills the ebreak and cancels the drain.
                if (evt) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = intr_req ? intr_vec : ex_jump_target;
                end else if (!ex_valid && !mem_valid && !wb_valid) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            halted_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            halted_q         <= halted_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign halted         = halted_q;
    assign ctrl_state     = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] flush_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (flush_id_ex && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (stall_id && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign flush_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

    localparam int XLEN = 64;
    localparam int RAW  = 5;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_jump;
    logic [XLEN-1:0] ex_jump_target;
    logic            intr_req;
    logic [XLEN-1:0] intr_vec;
    logic            id_ebreak;
    logic            id_valid, ex_valid, mem_valid, wb_valid;
    logic [RAW-1:0]  id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_is_load;
    logic            flush_if_id, flush_id_ex, stall_id, fetch_stop;
    logic            redirect_valid, halted;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      ctrl_state;
    logic [31:0]     flush_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
        .clk(clk), .rst(rst),
        .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
        .intr_req(intr_req), .intr_vec(intr_vec),
        .id_ebreak(id_ebreak),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_id(stall_id),
        .fetch_stop(fetch_stop),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .ctrl_state(ctrl_state),
        .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ex_jump = 0; ex_jump_target = '0; intr_req = 0; intr_vec = '0;
        id_ebreak = 0; id_valid = 0; ex_valid = 0; mem_valid = 0; wb_valid = 0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = '0; ex_is_load = 0;
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        clr();
        rst = 1;
        tick(); tick();
        rst = 0;
        settle();

        // Reset state
        chk("rst_state", 64'(ctrl_state), 0);
        chk("rst_rv", 64'(redirect_valid), 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_halted", 64'(halted), 0);
        chk("rst_comb", {60'd0, flush_if_id, flush_id_ex, stall_id, fetch_stop}, 0);
        chk("rst_cnt", {flush_cnt, stall_cnt}, 0);

        // Jump without ex_valid is not a jump
        ex_jump = 1; ex_jump_target = 64'h8000_0100;
        settle();
        chk("jmp_novalid_flush", 64'(flush_id_ex), 0);

        // Jump: same-cycle flush, next-cycle redirect (flush #1)
        ex_valid = 1;
        settle();
        chk("jmp_flush_if_id", 64'(flush_if_id), 1);
        chk("jmp_flush_id_ex", 64'(flush_id_ex), 1);
        tick();
        clr();
        // Jump arriving in REDIRECT is ignored
        ex_valid = 1; ex_jump = 1; ex_jump_target = 64'h1234;
        settle();
        chk("jmp_redir_state", 64'(ctrl_state), 1);
        chk("jmp_redir_rv", 64'(redirect_valid), 1);
        chk("jmp_redir_pc", redirect_pc, 64'h8000_0100);
        chk("redir_ignore_jmp", 64'(flush_id_ex), 0);
        tick();
        clr();
        settle();
        chk("jmp_back_state", 64'(ctrl_state), 0);
        chk("jmp_back_rv", 64'(redirect_valid), 0);
        chk("jmp_hold_pc", redirect_pc, 64'h8000_0100);

        // Interrupt beats jump (flush #2)
        intr_req = 1; intr_vec = 64'h8000_0800;
        ex_valid = 1; ex_jump = 1; ex_jump_target = 64'h8000_0100;
        settle();
        chk("intr_flush", 64'(flush_id_ex), 1);
        tick();
        clr();
        // Load-use pattern during REDIRECT must not stall
        id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        settle();
        chk("prio_pc", redirect_pc, 64'h8000_0800);
        chk("prio_rv", 64'(redirect_valid), 1);
        chk("redir_no_stall", 64'(stall_id), 0);
        tick();
        settle();

        // Load-use on rs2 (stall #1)
        chk("lu_rs2_stall", 64'(stall_id), 1);
        chk("lu_rs2_noflush", 64'(flush_id_ex), 0);
        tick();
        // Load-use on rs1 (stall #2)
        id_use_rs2 = 0; id_rs1 = 7; ex_rd = 7; id_use_rs1 = 1;
        settle();
        chk("lu_rs1_stall", 64'(stall_id), 1);
        tick();
        // Match but source not read
        id_use_rs1 = 0; id_rs2 = 7;
        settle();
        chk("lu_unused_src", 64'(stall_id), 0);
        // ex_rd = x0 never stalls
        id_use_rs2 = 1; id_rs2 = 0; ex_rd = 0;
        settle();
        chk("lu_x0", 64'(stall_id), 0);
        // Not a load
        ex_rd = 5; id_rs2 = 5; ex_is_load = 0;
        settle();
        chk("lu_notload", 64'(stall_id), 0);
        // Flush wins over stall (flush #3)
        ex_is_load = 1; ex_jump = 1; ex_jump_target = 64'h8000_0200;
        settle();
        chk("lu_jmp_stall", 64'(stall_id), 0);
        chk("lu_jmp_flush", 64'(flush_id_ex), 1);
        tick();
        clr();
        tick();
        settle();
        chk("cnt_flush", 64'(flush_cnt), PERF ? 3 : 0);
        chk("cnt_stall", 64'(stall_cnt), PERF ? 2 : 0);

        // Ebreak drain
        id_ebreak = 1; id_valid = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
        settle();
        chk("ebk_run_fs", 64'(fetch_stop), 0);
        tick();
        id_ebreak = 0; id_valid = 0;
        settle();
        chk("drain_state", 64'(ctrl_state), 2);
        chk("drain_fs0", 64'(fetch_stop), 1);
        chk("drain_fifid", 64'(flush_if_id), 1);
        chk("drain_fidex", 64'(flush_id_ex), 0);
        tick();
        ex_valid = 0;
        settle();
        chk("drain_fs1", 64'(fetch_stop), 1);
        chk("drain_state1", 64'(ctrl_state), 2);
        tick();
        mem_valid = 0;
        settle();
        chk("drain_fs2", 64'(fetch_stop), 1);
        tick();
        wb_valid = 0;
        settle();
        chk("drain_fs3", 64'(fetch_stop), 1);
        chk("drain_not_halted", 64'(halted), 0);
        tick();
        // HALT: sticky, events ignored
        intr_req = 1; intr_vec = 64'h9999; ex_valid = 1; ex_jump = 1;
        settle();
        chk("halt_state", 64'(ctrl_state), 3);
        chk("halt_halted", 64'(halted), 1);
        chk("halt_fs", 64'(fetch_stop), 1);
        chk("halt_noflush", {62'd0, flush_if_id, flush_id_ex}, 0);
        tick(); tick();
        settle();
        chk("halt_sticky", {62'd0, halted, redirect_valid}, 2);
        chk("halt_sticky_st", 64'(ctrl_state), 3);
        // Reset in HALT
        rst = 1;
        tick();
        rst = 0;
        clr();
        settle();
        chk("rst_halt_state", 64'(ctrl_state), 0);
        chk("rst_halt_halted", 64'(halted), 0);
        chk("rst_halt_cnt", {flush_cnt, stall_cnt}, 0);

        // Drain cancelled by jump (flush #1 after reset)
        id_ebreak = 1; id_valid = 1; ex_valid = 1;
        tick();
        id_ebreak = 0; id_valid = 0;
        ex_jump = 1; ex_jump_target = 64'h8000_0040;
        settle();
        chk("cancel_flush", {62'd0, flush_if_id, flush_id_ex}, 3);
        tick();
        clr();
        settle();
        chk("cancel_state", 64'(ctrl_state), 1);
        chk("cancel_pc", redirect_pc, 64'h8000_0040);
        chk("cancel_rv", 64'(redirect_valid), 1);
        chk("cancel_halted", 64'(halted), 0);
        tick();
        settle();
        chk("cancel_run", 64'(ctrl_state), 0);
        chk("cancel_fs", 64'(fetch_stop), 0);
        chk("cancel_cnt", 64'(flush_cnt), PERF ? 1 : 0);

        // Reset in DRAIN
        id_ebreak = 1; id_valid = 1; ex_valid = 1;
        tick();
        settle();
        chk("drain2_state", 64'(ctrl_state), 2);
        rst = 1;
        tick();
        rst = 0;
        clr();
        settle();
        chk("rst_drain_state", 64'(ctrl_state), 0);
        chk("rst_drain_halted", 64'(halted), 0);
        chk("rst_drain_cnt", {flush_cnt, stall_cnt}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
